// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/shift ops, multi-cycle multiply and
// restoring divide, one operation in flight behind a valid/ready handshake.
module alu_seq #(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           op,
  input  logic [WIDTH-1:0]     oprd1,
  input  logic [WIDTH-1:0]     oprd2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic [11:0]          flags,
  output logic                 err
);

  localparam int unsigned SH_W  = $clog2(WIDTH);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_SAR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_DIV = 4'd9;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t               state_q, state_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic [11:0]          flags_q, flags_d;
  logic                 err_q, err_d;
  logic [3:0]           op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d;     // multiplicand, or dividend/quotient shift register
  logic [WIDTH-1:0]     b_q, b_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [SH_W-1:0]      sh;
  logic [WIDTH:0]       sum_w, dif_w, shl_w, shr_w, sar_w;
  logic [2*WIDTH-1:0]   sc_res;
  logic [11:0]          sc_flags;
  logic                 sc_err;
  logic [WIDTH-1:0]     mul_a, mul_b;
  logic [2*WIDTH-1:0]   prod;
  logic [11:0]          mul_flags;
  logic [WIDTH:0]       rem_sh, trial;
  logic [WIDTH-1:0]     rem_nx, quo_nx;

  function automatic logic [11:0] flag_word(input logic [WIDTH-1:0] lo,
                                            input logic cf, input logic of);
    logic [11:0] f;
    f     = '0;
    f[0]  = cf;
    f[2]  = ~^lo[7:0];
    f[6]  = (lo == '0);
    f[7]  = lo[WIDTH-1];
    f[11] = of;
    return f;
  endfunction

  // Results for everything that completes on the acceptance edge
  always_comb begin
    sh       = oprd2[SH_W-1:0];
    sum_w    = {1'b0, oprd1} + {1'b0, oprd2};
    dif_w    = {1'b0, oprd1} - {1'b0, oprd2};
    shl_w    = {1'b0, oprd1} << sh;
    shr_w    = {oprd1, 1'b0} >> sh;
    sar_w    = $signed({oprd1, 1'b0}) >>> sh;
    sc_res   = '0;
    sc_flags = '0;
    sc_err   = 1'b0;
    case (op)
      OP_ADD: begin
        sc_res   = {{WIDTH{1'b0}}, sum_w[WIDTH-1:0]};
        sc_flags = flag_word(sum_w[WIDTH-1:0], sum_w[WIDTH],
                             (oprd1[WIDTH-1] == oprd2[WIDTH-1]) &&
                             (sum_w[WIDTH-1] != oprd1[WIDTH-1]));
      end
      OP_SUB: begin
        sc_res   = {{WIDTH{1'b0}}, dif_w[WIDTH-1:0]};
        sc_flags = flag_word(dif_w[WIDTH-1:0], dif_w[WIDTH],
                             (oprd1[WIDTH-1] != oprd2[WIDTH-1]) &&
                             (dif_w[WIDTH-1] != oprd1[WIDTH-1]));
      end
      OP_AND: begin
        sc_res   = {{WIDTH{1'b0}}, oprd1 & oprd2};
        sc_flags = flag_word(oprd1 & oprd2, 1'b0, 1'b0);
      end
      OP_OR: begin
        sc_res   = {{WIDTH{1'b0}}, oprd1 | oprd2};
        sc_flags = flag_word(oprd1 | oprd2, 1'b0, 1'b0);
      end
      OP_XOR: begin
        sc_res   = {{WIDTH{1'b0}}, oprd1 ^ oprd2};
        sc_flags = flag_word(oprd1 ^ oprd2, 1'b0, 1'b0);
      end
      OP_SHL: begin
        sc_res   = {{WIDTH{1'b0}}, shl_w[WIDTH-1:0]};
        sc_flags = flag_word(shl_w[WIDTH-1:0], shl_w[WIDTH], 1'b0);
      end
      OP_SHR: begin
        sc_res   = {{WIDTH{1'b0}}, shr_w[WIDTH:1]};
        sc_flags = flag_word(shr_w[WIDTH:1], shr_w[0], 1'b0);
      end
      OP_SAR: begin
        sc_res   = {{WIDTH{1'b0}}, sar_w[WIDTH:1]};
        sc_flags = flag_word(sar_w[WIDTH:1], sar_w[0], 1'b0);
      end
      OP_DIV: begin
        sc_res = {oprd1, {WIDTH{1'b1}}};
        sc_err = 1'b1;
      end
      OP_MUL: ;
      default: sc_err = 1'b1;
    endcase
  end

  // Shared multiplier: fed from the inputs on acceptance, from registers while busy
  always_comb begin
    mul_a     = (state_q == S_IDLE) ? oprd1 : a_q;
    mul_b     = (state_q == S_IDLE) ? oprd2 : b_q;
    prod      = {{WIDTH{1'b0}}, mul_a} * {{WIDTH{1'b0}}, mul_b};
    mul_flags = flag_word(prod[WIDTH-1:0], (prod[2*WIDTH-1:WIDTH] != '0),
                          (prod[2*WIDTH-1:WIDTH] != '0));
  end

  // One restoring-division step
  always_comb begin
    rem_sh = {rem_q, a_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, b_q};
    if (!trial[WIDTH]) begin
      rem_nx = trial[WIDTH-1:0];
      quo_nx = {a_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_nx = rem_sh[WIDTH-1:0];
      quo_nx = {a_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    err_d    = err_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          op_d  = op;
          a_d   = oprd1;
          b_d   = oprd2;
          rem_d = '0;
          if (op == OP_MUL && MUL_LAT > 1) begin
            state_d = S_BUSY;
            cnt_d   = CNT_W'(MUL_LAT - 1);
          end else if (op == OP_MUL) begin
            state_d  = S_DONE;
            result_d = prod;
            flags_d  = mul_flags;
            err_d    = 1'b0;
          end else if (op == OP_DIV && oprd2 != '0) begin
            state_d = S_BUSY;
            cnt_d   = CNT_W'(WIDTH);
          end else begin
            state_d  = S_DONE;
            result_d = sc_res;
            flags_d  = sc_flags;
            err_d    = sc_err;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (op_q == OP_DIV) begin
          a_d   = quo_nx;
          rem_d = rem_nx;
        end
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
          err_d   = 1'b0;
          if (op_q == OP_DIV) begin
            result_d = {rem_nx, quo_nx};
            flags_d  = flag_word(quo_nx, 1'b0, 1'b0);
          end else begin
            result_d = prod;
            flags_d  = mul_flags;
          end
        end
      end
      S_DONE: begin
        if (out_valid_q && out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      err_q       <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      err_q       <= err_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized self-checking bench for alu_seq against an arithmetic reference model.
module tb_alu_seq;

  localparam int unsigned WIDTH   = 64;
  localparam int unsigned MUL_LAT = 3;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_SAR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_DIV = 4'd9;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [63:0]  oprd1;
  logic [63:0]  oprd2;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] result;
  logic [11:0]  flags;
  logic         err;

  int checks;
  int errors;

  alu_seq #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .oprd1     (oprd1),
    .oprd2     (oprd2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour straight from the operation definitions
  task automatic model(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                       output logic [127:0] r, output logic [11:0] f, output logic e,
                       output int lat);
    logic [64:0]        w;
    logic signed [65:0] s;
    int                 shc;
    int                 ones;
    logic               cf;
    logic               of;
    shc = int'(b[5:0]);
    r = '0; f = '0; e = 1'b0; lat = 1; cf = 1'b0; of = 1'b0; s = '0;
    case (o)
      OP_ADD: begin
        w  = {1'b0, a} + {1'b0, b};
        r  = {64'd0, w[63:0]};
        cf = w[64];
        s  = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b});
      end
      OP_SUB: begin
        r  = {64'd0, a - b};
        cf = (a < b);
        s  = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b});
      end
      OP_AND: r = {64'd0, a & b};
      OP_OR:  r = {64'd0, a | b};
      OP_XOR: r = {64'd0, a ^ b};
      OP_SHL: begin
        r  = {64'd0, a << shc};
        cf = (shc != 0) ? a[64-shc] : 1'b0;
      end
      OP_SHR: begin
        r  = {64'd0, a >> shc};
        cf = (shc != 0) ? a[shc-1] : 1'b0;
      end
      OP_SAR: begin
        r  = {64'd0, 64'($signed(a) >>> shc)};
        cf = (shc != 0) ? a[shc-1] : 1'b0;
      end
      OP_MUL: begin
        r   = 128'(a) * 128'(b);
        cf  = (r[127:64] != 64'd0);
        of  = cf;
        lat = MUL_LAT;
      end
      OP_DIV: begin
        if (b == 64'd0) begin
          r = {a, 64'hFFFF_FFFF_FFFF_FFFF};
          e = 1'b1;
        end else begin
          r   = {a % b, a / b};
          lat = WIDTH + 1;
        end
      end
      default: e = 1'b1;
    endcase
    if (o == OP_ADD || o == OP_SUB)
      of = (s > 66'sd9223372036854775807) || (s < -66'sd9223372036854775808);
    if (!e) begin
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(r[i]);
      f[0]  = cf;
      f[2]  = ((ones % 2) == 0);
      f[6]  = (r[63:0] == 64'd0);
      f[7]  = r[63];
      f[11] = of;
    end
  endtask

  // One full transaction: accept, measure latency, hold under backpressure, handshake
  task automatic run_op(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                        input int hold);
    logic [127:0] er;
    logic [11:0]  ef;
    logic         ee;
    int           el;
    int           n;
    int           lat;
    int           bad_rdy;
    int           bad_hold;
    model(o, a, b, er, ef, ee, el);
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_idle", 128'(in_ready), 128'(1));
    op = o; oprd1 = a; oprd2 = b; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op       = 4'($urandom);
    oprd1    = {$urandom, $urandom};
    oprd2    = {$urandom, $urandom};
    lat = 0;
    bad_rdy = 0;
    do begin
      @(negedge clk);
      lat++;
      if (in_ready) bad_rdy++;
    end while (!out_valid && lat < 100);
    check("latency", 128'(lat), 128'(el));
    check("result", result, er);
    check("flags", 128'(flags), 128'(ef));
    check("err", 128'(err), 128'(ee));
    bad_hold = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!out_valid || in_ready || result !== er || flags !== ef || err !== ee) bad_hold++;
    end
    check("busy_in_ready_low", 128'(bad_rdy), 128'(0));
    if (hold > 0) check("hold_stable", 128'(bad_hold), 128'(0));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("post_hs_in_ready", 128'(in_ready), 128'(1));
    check("post_hs_out_valid", 128'(out_valid), 128'(0));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, 128'(in_ready), 128'(0));
    check({tag, "_out_valid"}, 128'(out_valid), 128'(0));
    check({tag, "_result"}, result, 128'(0));
    check({tag, "_flags"}, 128'(flags), 128'(0));
    check({tag, "_err"}, 128'(err), 128'(0));
  endtask

  function automatic logic [63:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'($urandom_range(0, 300));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    int hits;
    logic [3:0] ro;
    checks = 0; errors = 0;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; oprd1 = '0; oprd2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", 128'(in_ready), 128'(1));

    run_op(OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);
    run_op(OP_SUB, 64'h8000_0000_0000_0000, 64'd1, 0);
    run_op(OP_MUL, 64'h1_0000_0000, 64'h1_0000_0000, 2);
    run_op(OP_DIV, 64'd100, 64'd7, 0);
    run_op(OP_DIV, 64'd5, 64'd0, 1);
    run_op(OP_SHL, 64'd1, 64'd65, 10);
    run_op(OP_SHR, 64'hF0, 64'd0, 0);
    run_op(OP_SAR, 64'h8000_0000_0000_0003, 64'd63, 0);
    run_op(4'd12, 64'd3, 64'd4, 2);
    run_op(OP_XOR, 64'h1234, 64'h1234, 0);

    for (int k = 0; k < 60; k++) begin
      ro = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
      run_op(ro, rand_operand(), rand_operand(), $urandom_range(0, 3));
    end

    // Reset pulse in the middle of a division, with a request held during reset
    op = OP_DIV; oprd1 = {$urandom, $urandom}; oprd2 = 64'd3; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) hits++;
    end
    reset = 1'b1;
    in_valid = 1'b1; op = OP_ADD; oprd1 = 64'd7; oprd2 = 64'd8;
    @(negedge clk);
    check_reset_state("mid_div_reset");
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("in_ready_after_abort", 128'(in_ready), 128'(1));
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (out_valid) hits++;
    end
    check("aborted_div_no_output", 128'(hits), 128'(0));
    run_op(OP_ADD, 64'd2, 64'd3, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
